// File: rtl/collision_scheduler_pkg.sv
// Shared game package: default geometry and the scheduler state encoding.
package collision_scheduler_pkg;

  localparam int DEF_COORD_W    = 10;
  localparam int DEF_PAC_SIZE   = 16;
  localparam int DEF_GHOST_SIZE = 16;
  localparam int DEF_NUM_GHOSTS = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/collision_scheduler_box_overlap.sv
// Strict axis-aligned bounding-box overlap test. Sums are one bit wider than
// the coordinates so boxes near the right/bottom edge of the field never wrap.
module box_overlap #(
  parameter int COORD_W = 10,
  parameter int A_SIZE  = 16,
  parameter int B_SIZE  = 16
) (
  input  logic [COORD_W-1:0] i_ax,
  input  logic [COORD_W-1:0] i_ay,
  input  logic [COORD_W-1:0] i_bx,
  input  logic [COORD_W-1:0] i_by,
  output logic               o_hit
);

  localparam logic [COORD_W:0] A_W = (COORD_W+1)'(A_SIZE);
  localparam logic [COORD_W:0] B_W = (COORD_W+1)'(B_SIZE);

  logic [COORD_W:0] w_ax, w_ay, w_bx, w_by;

  assign w_ax = {1'b0, i_ax};
  assign w_ay = {1'b0, i_ay};
  assign w_bx = {1'b0, i_bx};
  assign w_by = {1'b0, i_by};

  // Touching edges do not count: every comparison is strict.
  assign o_hit = (w_ax + A_W > w_bx) && (w_ax < w_bx + B_W) &&
                 (w_ay + A_W > w_by) && (w_ay < w_by + B_W);

endmodule

// File: rtl/collision_scheduler.sv
// Time-multiplexed collision controller: snapshots positions on frame_tick,
// sweeps one shared overlap checker across the ghosts one per clock, then
// publishes hit / eaten / death results with a one-cycle done pulse.
module collision_scheduler
  import collision_scheduler_pkg::*;
#(
  parameter int NUM_GHOSTS = DEF_NUM_GHOSTS,
  parameter int COORD_W    = DEF_COORD_W,
  parameter int PAC_SIZE   = DEF_PAC_SIZE,
  parameter int GHOST_SIZE = DEF_GHOST_SIZE
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_tick,
  input  logic [COORD_W-1:0]            player_x,
  input  logic [COORD_W-1:0]            player_y,
  input  logic [NUM_GHOSTS*COORD_W-1:0] ghost_x,
  input  logic [NUM_GHOSTS*COORD_W-1:0] ghost_y,
  input  logic [NUM_GHOSTS-1:0]         frightened,
  output logic                          busy,
  output logic                          done,
  output logic [NUM_GHOSTS-1:0]         hit_vec,
  output logic [NUM_GHOSTS-1:0]         eaten_vec,
  output logic                          pac_death,
  output logic                          overrun
);

  localparam int                IDX_W    = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_GHOSTS - 1);

  state_t                               r_state, w_state_nxt;
  logic   [IDX_W-1:0]                   r_idx;
  logic   [COORD_W-1:0]                 r_px, r_py;
  logic   [NUM_GHOSTS-1:0][COORD_W-1:0] r_gx, r_gy;
  logic   [NUM_GHOSTS-1:0]              r_fright;
  logic   [NUM_GHOSTS-1:0]              r_hit_acc, w_acc_nxt;
  logic   [NUM_GHOSTS-1:0]              r_hit_vec, r_eaten;
  logic                                 r_death, r_done, r_overrun;
  logic                                 w_start, w_last, w_hit;
  logic   [NUM_GHOSTS-1:0][COORD_W-1:0] w_gx_in, w_gy_in;

  assign w_gx_in = ghost_x;
  assign w_gy_in = ghost_y;

  // Single shared comparator, fed from the snapshot at the current index.
  box_overlap #(
    .COORD_W (COORD_W),
    .A_SIZE  (PAC_SIZE),
    .B_SIZE  (GHOST_SIZE)
  ) u_overlap (
    .i_ax  (r_px),
    .i_ay  (r_py),
    .i_bx  (r_gx[r_idx]),
    .i_by  (r_gy[r_idx]),
    .o_hit (w_hit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state plus start/last strobes for the datapath.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: if (frame_tick) begin
        w_start     = 1'b1;
        w_state_nxt = SCAN;
      end
      SCAN: if (r_idx == LAST_IDX) begin
        w_last      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Accumulator with the current ghost's result merged in, so the publish
  // edge sees the last ghost too.
  always_comb begin
    w_acc_nxt        = r_hit_acc;
    w_acc_nxt[r_idx] = w_hit;
  end

  // Snapshot capture, sweep bookkeeping, result publish and overrun flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx     <= '0;
      r_px      <= '0;
      r_py      <= '0;
      r_gx      <= '0;
      r_gy      <= '0;
      r_fright  <= '0;
      r_hit_acc <= '0;
      r_hit_vec <= '0;
      r_eaten   <= '0;
      r_death   <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (frame_tick && r_state == SCAN) r_overrun <= 1'b1;
      if (w_start) begin
        r_px      <= player_x;
        r_py      <= player_y;
        r_gx      <= w_gx_in;
        r_gy      <= w_gy_in;
        r_fright  <= frightened;
        r_hit_acc <= '0;
        r_idx     <= '0;
      end
      if (r_state == SCAN) begin
        r_hit_acc <= w_acc_nxt;
        r_idx     <= r_idx + IDX_W'(1);
      end
      if (w_last) begin
        r_idx     <= '0;
        r_hit_vec <= w_acc_nxt;
        r_eaten   <= w_acc_nxt & r_fright;
        r_death   <= |(w_acc_nxt & ~r_fright);
        r_done    <= 1'b1;
      end
    end
  end

  assign busy      = (r_state == SCAN);
  assign done      = r_done;
  assign hit_vec   = r_hit_vec;
  assign eaten_vec = r_eaten;
  assign pac_death = r_death;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_collision_scheduler.sv
// Randomized scoreboard bench for collision_scheduler.
module tb_collision_scheduler;

  localparam int N  = 4;
  localparam int W  = 10;
  localparam int PS = 16;
  localparam int GS = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           frame_tick = 1'b0;
  logic [W-1:0]   player_x = '0, player_y = '0;
  logic [N*W-1:0] ghost_x = '0, ghost_y = '0;
  logic [N-1:0]   frightened = '0;
  logic           busy, done, pac_death, overrun;
  logic [N-1:0]   hit_vec, eaten_vec;

  collision_scheduler #(.NUM_GHOSTS(N), .COORD_W(W), .PAC_SIZE(PS), .GHOST_SIZE(GS)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .player_x(player_x), .player_y(player_y),
    .ghost_x(ghost_x), .ghost_y(ghost_y), .frightened(frightened),
    .busy(busy), .done(done), .hit_vec(hit_vec), .eaten_vec(eaten_vec),
    .pac_death(pac_death), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] hit;
    logic [N-1:0] eaten;
    logic         death;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  int           pxv, pyv;
  int           gxa[N], gya[N];
  logic [N-1:0] frv;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: boxes overlap when their open intervals intersect on both axes.
  function automatic bit ovl(int px, int py, int gx, int gy);
    return (px + PS > gx) && (px < gx + GS) && (py + PS > gy) && (py < gy + GS);
  endfunction

  function automatic exp_t model();
    exp_t e;
    e.hit = '0;
    for (int i = 0; i < N; i++) e.hit[i] = ovl(pxv, pyv, gxa[i], gya[i]);
    e.eaten = e.hit & frv;
    e.death = |(e.hit & ~frv);
    e.cyc   = 0;
    return e;
  endfunction

  task automatic far_all();
    for (int i = 0; i < N; i++) begin gxa[i] = 300; gya[i] = 300; end
  endtask

  task automatic drive_inputs();
    player_x = W'(pxv);
    player_y = W'(pyv);
    for (int i = 0; i < N; i++) begin
      ghost_x[i*W +: W] = W'(gxa[i]);
      ghost_y[i*W +: W] = W'(gya[i]);
    end
    frightened = frv;
  endtask

  task automatic scramble();
    player_x   = W'($urandom_range(0, 1023));
    player_y   = W'($urandom_range(0, 1023));
    ghost_x    = {$urandom, $urandom};
    ghost_y    = {$urandom, $urandom};
    frightened = N'($urandom);
  endtask

  // Issue one scan, scramble inputs while it runs, return at the done cycle.
  task automatic do_scan(input bit chk_busy);
    exp_t e;
    drive_inputs();
    frame_tick = 1'b1;
    e = model();
    e.cyc = cyc + N + 1;
    q.push_back(e);
    @(negedge clk);
    frame_tick = 1'b0;
    if (chk_busy) check("busy_scan", busy, 1);
    scramble();
    repeat (N) begin @(negedge clk); scramble(); end
    if (chk_busy) check("busy_done", busy, 0);
  endtask

  function automatic int clampc(int v);
    return (v < 0) ? 0 : (v > 1023) ? 1023 : v;
  endfunction

  // Monitor: every done must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst && done) begin
      if (q.size() == 0) check("unexpected_done", done, 0);
      else begin
        e = q.pop_front();
        check("hit_vec", hit_vec, e.hit);
        check("eaten_vec", eaten_vec, e.eaten);
        check("pac_death", pac_death, e.death);
        check("latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hit", hit_vec, 0);
    check("rst_eaten", eaten_vec, 0);
    check("rst_death", pac_death, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b1;
    @(negedge clk);

    // Directed: no hit.
    pxv = 100; pyv = 100; far_all(); frv = '0;
    do_scan(1);
    check("t1_hit", hit_vec, 4'b0000);
    check("t1_death", pac_death, 0);

    // Ghost 2 overlapping, not frightened -> death.
    gxa[2] = 110; gya[2] = 108;
    do_scan(1);
    check("t2_hit", hit_vec, 4'b0100);
    check("t2_eaten", eaten_vec, 4'b0000);
    check("t2_death", pac_death, 1);

    // Same, frightened -> eaten.
    frv = 4'b0100;
    do_scan(0);
    check("t3_eaten", eaten_vec, 4'b0100);
    check("t3_death", pac_death, 0);

    // Edge touching only.
    far_all(); frv = '0; gxa[0] = 116; gya[0] = 100;
    do_scan(0);
    check("t4_touch", hit_vec, 4'b0000);

    // Near the field limit: no wrap.
    pxv = 1015; pyv = 1015; far_all(); gxa[0] = 1020; gya[0] = 1020;
    do_scan(0);
    check("t5_wrap_hit", hit_vec, 4'b0001);
    pxv = 1015; pyv = 0; far_all(); gxa[0] = 0; gya[0] = 0;
    do_scan(0);
    check("t6_wrap_miss", hit_vec, 4'b0000);

    // Random back-to-back scans, ghosts biased to land near the player.
    for (int k = 0; k < 60; k++) begin
      pxv = $urandom_range(0, 1023);
      pyv = $urandom_range(0, 1023);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) != 0) begin
          gxa[i] = clampc(pxv + int'($urandom_range(0, 40)) - 20);
          gya[i] = clampc(pyv + int'($urandom_range(0, 40)) - 20);
        end else begin
          gxa[i] = $urandom_range(0, 1023);
          gya[i] = $urandom_range(0, 1023);
        end
      end
      frv = N'($urandom);
      do_scan(k < 4);
    end
    check("no_overrun_yet", overrun, 0);

    // Overrun: second tick mid-scan is ignored, snapshot holds.
    pxv = 100; pyv = 100; far_all(); frv = '0;
    do_scan(0);
    drive_inputs();
    frame_tick = 1'b1;
    begin
      exp_t e;
      e = model();
      e.cyc = cyc + N + 1;
      q.push_back(e);
    end
    @(negedge clk);
    frame_tick = 1'b0;
    ghost_x[0 +: W] = W'(110);
    ghost_y[0 +: W] = W'(100);
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (N + 3) @(negedge clk);
    check("overrun_set", overrun, 1);
    check("overrun_hit", hit_vec, 4'b0000);
    check("overrun_q", q.size(), 0);

    // Leave a hit result, then reset two cycles into a scan.
    gxa[1] = 105; gya[1] = 95;
    do_scan(0);
    check("pre_rst_hit", hit_vec, 4'b0010);
    drive_inputs();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_hit", hit_vec, 0);
    check("mid_rst_death", pac_death, 0);
    check("mid_rst_overrun", overrun, 0);
    @(negedge clk);
    check("mid_rst_done", done, 0);
    rst = 1'b1;
    repeat (N + 2) @(negedge clk);
    check("post_rst_idle", busy, 0);
    check("post_rst_hit", hit_vec, 0);

    // Fresh scan after release.
    frv = 4'b0010;
    do_scan(1);
    check("post_rst_eaten", eaten_vec, 4'b0010);

    repeat (3) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
